rv32_imm_enc: RTL and testbench

//  Immediate encoder: inverse of the core's immediate decode. Takes a 32-bit immediate, an
//  rv32_type_enum_t format and a base instruction word (opcode/rd/rs/funct bits), and packs
//  the immediate into the format's bit positions. Feeds the program loader/self-test path.

---
 rtl/rv32_imm_enc_if.sv | 36 +++
 rtl/rv32_imm_enc.sv | 108 ++++++++++
 tb/tb_rv32_imm_enc.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_imm_enc_if.sv
// rtl/rv32_imm_enc_if.sv - shared types and request/response bus for the immediate encoder
package rv32_imm_enc_pkg;
  typedef logic [31:0] rv_imm_t;
  typedef logic [31:0] rv32_instr_t;
  typedef enum logic [2:0] {
    RV32_I = 3'd0,
    RV32_S = 3'd1,
    RV32_B = 3'd2,
    RV32_U = 3'd3,
    RV32_J = 3'd4
  } rv32_type_enum_t;
endpackage

interface rv32_imm_enc_if;
  import rv32_imm_enc_pkg::*;

  logic            in_valid;
  logic            in_ready;
  rv32_type_enum_t in_type;
  rv_imm_t         in_imm;
  rv32_instr_t     in_base;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic            out_err;

  modport master (
    output in_valid, in_type, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_type, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/rv32_imm_enc.sv
// rtl/rv32_imm_enc.sv - packs an immediate into an RV32 instruction word, buffered in an output FIFO
module rv32_imm_enc
  import rv32_imm_enc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  rv32_imm_enc_if.slave                 bus,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic [ERR_CNT_W-1:0]          err_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  rv_imm_t      imm;
  logic [31:0]  enc_instr;
  logic         enc_err;
  logic         i_range_err;
  logic         j_range_err;

  assign imm         = bus.in_imm;
  // Signed 12-bit (and 20-bit for J) fields fit only when all bits above the sign bit match it.
  assign i_range_err = !((&imm[31:11]) || !(|imm[31:11]));
  assign j_range_err = !((&imm[31:19]) || !(|imm[31:19]));

  always_comb begin
    enc_instr = bus.in_base;
    enc_err   = 1'b0;
    case (bus.in_type)
      RV32_S: begin
        enc_instr[31:25] = imm[11:5];
        enc_instr[11:7]  = imm[4:0];
        enc_err          = i_range_err;
      end
      RV32_B: begin
        enc_instr[31]    = imm[11];
        enc_instr[7]     = imm[10];
        enc_instr[30:25] = imm[9:4];
        enc_instr[11:8]  = imm[3:0];
        enc_err          = i_range_err;
      end
      RV32_U: begin
        enc_instr[31:12] = imm[31:12];
        enc_err          = |imm[11:0];
      end
      RV32_J: begin
        enc_instr[31]    = imm[19];
        enc_instr[19:12] = imm[18:11];
        enc_instr[20]    = imm[10];
        enc_instr[30:21] = imm[9:0];
        enc_err          = j_range_err;
      end
      default: begin
        enc_instr[31:20] = imm[11:0];
        enc_err          = i_range_err;
      end
    endcase
  end

  logic [32:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full          = (level == LVL_W'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign push          = bus.in_valid && !full && !flush;
  assign pop           = !empty && bus.out_ready;
  assign bus.out_instr = empty ? 32'd0 : mem[rd_ptr][31:0];
  assign bus.out_err   = empty ? 1'b0  : mem[rd_ptr][32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      err_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {enc_err, enc_instr};
        wr_ptr      <= wr_ptr + 1'b1;
        if (enc_err && !(&err_cnt)) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32_imm_enc.sv
// tb/tb_rv32_imm_enc.sv - directed self-checking bench for rv32_imm_enc
module tb_rv32_imm_enc;
  import rv32_imm_enc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] level;
  logic [7:0] err_cnt;
  int         total;
  int         bad;

  rv32_imm_enc_if bus();

  rv32_imm_enc #(.FIFO_DEPTH(4), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .level   (level),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input rv32_type_enum_t t, input logic [31:0] imm, input logic [31:0] base);
    bus.in_type  = t;
    bus.in_imm   = imm;
    bus.in_base  = base;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0 || bus.out_err !== 1'b0) begin
      bad++; $display("FAIL reset_out got v=%b i=%h e=%b exp 0/0/0", bus.out_valid, bus.out_instr, bus.out_err);
    end
    total++;
    if (bus.in_ready !== 1'b1 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_ready_cnt got rdy=%b cnt=%0d exp 1/0", bus.in_ready, err_cnt);
    end
  endtask

  task automatic test_i();
    push(RV32_I, 32'hFFFF_FFFF, 32'h0000_0013);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF0_0013 || bus.out_err !== 1'b0) begin
      bad++; $display("FAIL i_neg1 got v=%b i=%h e=%b exp 1/fff00013/0", bus.out_valid, bus.out_instr, bus.out_err);
    end
    pop_one();
    total++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL i_pop got lvl=%0d v=%b exp 0/0", level, bus.out_valid);
    end
  endtask

  task automatic test_i_range();
    push(RV32_I, 32'h0000_0800, 32'h0000_0013);
    total++;
    if (bus.out_instr !== 32'h8000_0013 || bus.out_err !== 1'b1 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL i_range got i=%h e=%b cnt=%0d exp 80000013/1/1", bus.out_instr, bus.out_err, err_cnt);
    end
    pop_one();
  endtask

  task automatic test_u();
    push(RV32_U, 32'h1234_5000, 32'h0000_0037);
    push(RV32_U, 32'h1234_5001, 32'h0000_0037);
    total++;
    if (level !== 3'd2 || bus.out_instr !== 32'h1234_5037 || bus.out_err !== 1'b0) begin
      bad++; $display("FAIL u_ok got lvl=%0d i=%h e=%b exp 2/12345037/0", level, bus.out_instr, bus.out_err);
    end
    pop_one();
    total++;
    if (bus.out_instr !== 32'h1234_5037 || bus.out_err !== 1'b1 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL u_err got i=%h e=%b cnt=%0d exp 12345037/1/2", bus.out_instr, bus.out_err, err_cnt);
    end
    pop_one();
  endtask

  task automatic test_bjs();
    logic [31:0] exp_v [4];
    exp_v[0] = 32'hFE00_0EE3;
    exp_v[1] = 32'h0020_006F;
    exp_v[2] = 32'hFE00_0FA3;
    exp_v[3] = 32'h0050_0013;
    push(RV32_B, 32'hFFFF_FFFE, 32'h0000_0063);
    push(RV32_J, 32'h0000_0001, 32'h0000_006F);
    push(RV32_S, 32'hFFFF_FFFF, 32'h0000_0023);
    push(rv32_type_enum_t'(3'd7), 32'h0000_0005, 32'h0000_0013);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.out_instr !== exp_v[k] || bus.out_err !== 1'b0) begin
        bad++; $display("FAIL bjs_%0d got i=%h e=%b exp %h/0", k, bus.out_instr, bus.out_err, exp_v[k]);
      end
      pop_one();
    end
    total++;
    if (err_cnt !== 8'd2) begin bad++; $display("FAIL bjs_cnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_full();
    int got;
    int cyc;
    bit acc5;
    bit will_acc;
    for (int k = 0; k < 4; k++) push(RV32_I, 32'(k + 1), 32'h0000_0013);
    total++;
    if (level !== 3'd4 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL full got lvl=%0d rdy=%b exp 4/0", level, bus.in_ready);
    end
    bus.in_type   = RV32_I;
    bus.in_imm    = 32'd5;
    bus.in_base   = 32'h0000_0013;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    got  = 0;
    cyc  = 0;
    acc5 = 1'b0;
    while (got < 5 && cyc < 20) begin
      if (bus.out_valid === 1'b1) begin
        total++;
        if (bus.out_instr !== ((32'(got + 1) << 20) | 32'h13)) begin
          bad++; $display("FAIL order_%0d got=%h exp=%h", got, bus.out_instr, (32'(got + 1) << 20) | 32'h13);
        end
        got++;
      end
      will_acc = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (will_acc) begin
        bus.in_valid = 1'b0;
        acc5 = 1'b1;
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++;
    if (got != 5 || !acc5 || level !== 3'd0) begin
      bad++; $display("FAIL drain got pops=%0d acc5=%b lvl=%0d exp 5/1/0", got, acc5, level);
    end
  endtask

  task automatic test_flush_reset();
    for (int k = 0; k < 3; k++) push(RV32_I, 32'd1, 32'h13);
    bus.in_type  = RV32_U;
    bus.in_imm   = 32'd1;
    bus.in_valid = 1'b1;
    flush        = 1'b1;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    total++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || err_cnt !== 8'd2) begin
      bad++; $display("FAIL flush got lvl=%0d v=%b rdy=%b cnt=%0d exp 0/0/1/2", level, bus.out_valid, bus.in_ready, err_cnt);
    end
    for (int k = 0; k < 3; k++) push(RV32_I, 32'd1, 32'h13);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0 || err_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_reset got lvl=%0d v=%b cnt=%0d exp 0/0/0", level, bus.out_valid, err_cnt);
    end
  endtask

  task automatic test_saturate();
    bus.in_type   = RV32_U;
    bus.in_imm    = 32'd1;
    bus.in_base   = 32'h37;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    bus.in_valid  = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    total++;
    if (err_cnt !== 8'd255 || level !== 3'd0) begin
      bad++; $display("FAIL saturate got cnt=%0d lvl=%0d exp 255/0", err_cnt, level);
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_type   = RV32_I;
    bus.in_imm    = 32'd0;
    bus.in_base   = 32'd0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    test_i();
    test_i_range();
    test_u();
    test_bjs();
    test_full();
    test_flush_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
